soc_sram_dp_impl_plain: RTL and testbench
=========================================

# soc_sram_dp_impl_plain

True dual-port, byte-writable on-chip SRAM. Successor to the single-port plain SRAM, used by the tile memory and DMA/NoC adapters when two masters need concurrent access. Adds:
- a second independent port,
- arbitrary byte-multiple data width,
- a selectable 1- or 2-cycle read pipeline with read-valid strobes,
- deterministic write collision rules,
- an optional hardware zero-clear sequencer after reset.

## Interface
Parameters:
- AW, 32, byte address width
- DW, 32, data width; any multiple of 8
- SW, DW/8 (localparam), byte lanes
- WORD_AW, AW - clog2(SW), word address width
- MEM_SIZE_BYTE, 'hx, memory size in bytes; must be a multiple of SW
- MEM_SIZE_WORDS, MEM_SIZE_BYTE/SW (localparam)
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2
- CLEAR_ON_RESET, 0, when 1, zero all words after reset release
- MEM_FILE, "sram.vmem", simulation init file; not loaded when CLEAR_ON_RESET=1

Ports (the clock is clk; the reset is rst, synchronous, active-low):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- busy  out  1  clear sequencer running; both ports ignored while high
- a_ce  in  1  port A access request
- a_we  in  1  port A write (1) / read (0), qualified by a_ce
- a_waddr  in  WORD_AW  port A word address
- a_din  in  DW  port A write data
- a_sel  in  SW  port A byte enables
- a_dout  out  DW  port A read data
- a_rvalid  out  1  a_dout valid strobe
- b_ce, b_we, b_waddr, b_din, b_sel, b_dout, b_rvalid: identical to port A, for port B

## Operation
- Accepted access: xce=1 and busy=0. A read is xce & ~xwe. A write is xce & xwe; it updates only lanes with xsel[i]=1.
- Same-port read-during-write: does not occur, because reads and writes are exclusive per port. Addresses outside MEM_SIZE_WORDS are undefined; no wrap is required.
- Write/write collision (both ports write the same address in one cycle): per byte lane, port A wins where a_sel[i]=1. Lanes selected only by B take B's data.
- Read/write cross-port collision (A reads the address B writes, or vice versa): governed by the Configuration macro.
- Clear sequencer FSM states:
  - RST: while rst=0.
  - CLEAR: entered on rst rising, only if CLEAR_ON_RESET=1. Writes all-zero to one word per cycle, counter 0 → MEM_SIZE_WORDS-1.
  - READY: reached after the last word, or directly from RST when CLEAR_ON_RESET=0.
- Reset values:
  - a_dout, b_dout = 0
  - a_rvalid, b_rvalid = 0
  - busy = CLEAR_ON_RESET
  - clear counter = 0
  - memory contents are not reset.
- Reset asserted during CLEAR: the counter returns to 0 and the clear restarts fully after release.
- Reads in flight when reset asserts are dropped; no rvalid is produced.

## Timing
- Write commits at the accepting clk edge. A read of that address issued on the next cycle returns the new data.
- READ_LATENCY=1: xdout and xrvalid update at the edge after acceptance, and xrvalid is high for exactly 1 cycle.
- READ_LATENCY=2: one additional output register stage, so data and valid appear one cycle later.
- Back-to-back reads each yield one rvalid pulse, in order, with full throughput on both ports.
- xdout holds its last value when no read completes.
- busy falls on the edge after word MEM_SIZE_WORDS-1 is cleared, so CLEAR lasts exactly MEM_SIZE_WORDS cycles. A request in the first cycle with busy=0 is accepted.
- Requests presented while busy=1 are dropped, not queued, and produce no rvalid.

## Configuration
- SOC_SRAM_DP_FWD_EN defined: a cross-port read of an address written in the same cycle returns write-first data. Lanes with the writer's sel=1 take the writer's din; other lanes return old contents. Write/write merging is applied first.
- SOC_SRAM_DP_FWD_EN undefined: such a read returns the pre-write (old) word. This maps to a plain read-first BRAM.
- All other behaviour is identical in both builds.

## Test plan
- DW=32, READ_LATENCY=1. A writes 0xDEADBEEF to word 5 with sel=4'b1111, then A writes sel=4'b0010, din=0x00005500. B reads word 5 → b_dout=0xDEAD55EF and b_rvalid pulses 1 cycle after the read.
- Same cycle: A writes 0x11111111 with sel=4'b0011, B writes 0x22222222 with sel=4'b1111, both to word 9. A subsequent read returns 0x22221111.
- Word 3 holds 0xAAAAAAAA. In one cycle B writes 0x12345678 with sel=4'b1100 while A reads word 3.
  - With FWD_EN: a_dout=0x1234AAAA.
  - Without FWD_EN: a_dout=0xAAAAAAAA.
  - A read on the next cycle returns 0x1234AAAA in both builds.
- CLEAR_ON_RESET=1, MEM_SIZE_BYTE=64 (16 words). Release rst: busy stays high for exactly 16 cycles and all words read 0. Reassert rst at clear cycle 7: after release busy again stays high for 16 cycles.
- READ_LATENCY=2. Four back-to-back A reads of words 0..3 → four consecutive rvalid pulses starting 2 cycles after the first request, with data in order.
- Requests issued while busy=1 → no rvalid and no memory change. Reset during an outstanding read → rvalid=0 and dout=0.

Source files
------------

// File: rtl/soc_sram_dp_impl_plain.sv
// True dual-port, byte-writable SRAM with optional zero-clear after reset.
// Read latency is 1 or 2 cycles (READ_LATENCY). Write/write collisions
// merge per lane, and port A wins on overlapping lanes.
// Build option SOC_SRAM_DP_FWD_EN: when defined, a read returns write-first
// data if the other port writes the same word in the same cycle. When it is
// undefined, the read returns the old word (read-first BRAM).
module soc_sram_dp_impl_plain #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned WORD_AW        = AW - $clog2(DW / 8),
  parameter int unsigned MEM_SIZE_BYTE  = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter string       MEM_FILE       = "sram.vmem"
) (
  input  logic               clk,
  input  logic               rst,
  output logic               busy,
  input  logic               a_ce,
  input  logic               a_we,
  input  logic [WORD_AW-1:0] a_waddr,
  input  logic [DW-1:0]      a_din,
  input  logic [DW/8-1:0]    a_sel,
  output logic [DW-1:0]      a_dout,
  output logic               a_rvalid,
  input  logic               b_ce,
  input  logic               b_we,
  input  logic [WORD_AW-1:0] b_waddr,
  input  logic [DW-1:0]      b_din,
  input  logic [DW/8-1:0]    b_sel,
  output logic [DW-1:0]      b_dout,
  output logic               b_rvalid
);

  localparam int unsigned SW             = DW / 8;
  localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW;
  localparam int unsigned IdxW           = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(MEM_SIZE_WORDS - 1);

  localparam logic [1:0] StRst   = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  // No image is preloaded in RTL; MEM_FILE stays so existing instantiations carry
  // over, and simulation harnesses preload mem_q hierarchically.
  if (MEM_FILE == "") begin : g_no_image
  end

  logic [DW-1:0]   mem_q [MEM_SIZE_WORDS];
  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
  logic            clr_we;

  logic            a_acc, a_rd, a_wr, b_acc, b_rd, b_wr;
  logic [IdxW-1:0] a_idx, b_idx;
  logic [DW-1:0]   a_rdata, b_rdata;

  logic            a_v1_q, b_v1_q;
  logic [DW-1:0]   a_d1_q, b_d1_q;

  // Clear sequencer: one zero word per cycle. The first word is written while
  // still in StRst, so busy lasts exactly MEM_SIZE_WORDS cycles after release.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      StRst, StClear: begin
        if (CLEAR_ON_RESET) begin
          clr_we = 1'b1;
          if (clr_cnt_q == LastIdx) begin
            state_d = StReady;
          end else begin
            state_d   = StClear;
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end else begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
      default: state_d = StReady;
    endcase
  end

  // Sequencer state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRst;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy  = CLEAR_ON_RESET && (state_q != StReady);

  assign a_acc = a_ce & ~busy & rst;
  assign b_acc = b_ce & ~busy & rst;
  assign a_rd  = a_acc & ~a_we;
  assign a_wr  = a_acc & a_we;
  assign b_rd  = b_acc & ~b_we;
  assign b_wr  = b_acc & b_we;
  assign a_idx = a_waddr[IdxW-1:0];
  assign b_idx = b_waddr[IdxW-1:0];

  // Read data for each port, optionally forwarding the other port's write lanes.
  always_comb begin
    a_rdata = mem_q[a_idx];
    b_rdata = mem_q[b_idx];
`ifdef SOC_SRAM_DP_FWD_EN
    for (int i = 0; i < SW; i++) begin
      if (b_wr && (b_waddr == a_waddr) && b_sel[i]) a_rdata[8*i +: 8] = b_din[8*i +: 8];
      if (a_wr && (a_waddr == b_waddr) && a_sel[i]) b_rdata[8*i +: 8] = a_din[8*i +: 8];
    end
`endif
  end

  // Storage array: clear writes, then B lanes, then A lanes so A wins overlaps.
  always_ff @(posedge clk) begin
    if (clr_we && rst) begin
      mem_q[clr_cnt_q] <= '0;
    end
    for (int i = 0; i < SW; i++) begin
      if (b_wr && b_sel[i]) mem_q[b_idx][8*i +: 8] <= b_din[8*i +: 8];
      if (a_wr && a_sel[i]) mem_q[a_idx][8*i +: 8] <= a_din[8*i +: 8];
    end
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_rd;
      b_v1_q <= b_rd;
      if (a_rd) a_d1_q <= a_rdata;
      if (b_rd) b_d1_q <= b_rdata;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic          a_v2_q, b_v2_q;
    logic [DW-1:0] a_d2_q, b_d2_q;

    // Extra output register stage; in-flight reads are dropped on reset.
    always_ff @(posedge clk) begin
      if (!rst) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end

    assign a_dout   = a_d2_q;
    assign a_rvalid = a_v2_q;
    assign b_dout   = b_d2_q;
    assign b_rvalid = b_v2_q;
  end else begin : g_lat1
    assign a_dout   = a_d1_q;
    assign a_rvalid = a_v1_q;
    assign b_dout   = b_d1_q;
    assign b_rvalid = b_v1_q;
  end

endmodule

// File: tb/tb_soc_sram_dp_impl_plain.sv
// Bench for soc_sram_dp_impl_plain. It uses two instances:
// u_rl1 has 1-cycle reads and no clear; u_rl2 has 2-cycle reads and clear-on-reset.
// Read expectations are queued per port when a request is driven, and they are
// compared, together with the arrival cycle, when rvalid pulses.
module tb_soc_sram_dp_impl_plain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_a1[$], q_b1[$], q_a2[$], q_b2[$];
  logic [31:0] m1 [16];
  logic [31:0] m2 [16];

  logic        rst1, x_busy, x_a_ce, x_a_we, x_a_rvalid, x_b_ce, x_b_we, x_b_rvalid;
  logic [3:0]  x_a_waddr, x_a_sel, x_b_waddr, x_b_sel;
  logic [31:0] x_a_din, x_a_dout, x_b_din, x_b_dout;
  logic        rst2, y_busy, y_a_ce, y_a_we, y_a_rvalid, y_b_ce, y_b_we, y_b_rvalid;
  logic [3:0]  y_a_waddr, y_a_sel, y_b_waddr, y_b_sel;
  logic [31:0] y_a_din, y_a_dout, y_b_din, y_b_dout;

  soc_sram_dp_impl_plain #(
    .AW(6), .DW(32), .MEM_SIZE_BYTE(64), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
  ) u_rl1 (
    .clk(clk), .rst(rst1), .busy(x_busy),
    .a_ce(x_a_ce), .a_we(x_a_we), .a_waddr(x_a_waddr), .a_din(x_a_din), .a_sel(x_a_sel),
    .a_dout(x_a_dout), .a_rvalid(x_a_rvalid),
    .b_ce(x_b_ce), .b_we(x_b_we), .b_waddr(x_b_waddr), .b_din(x_b_din), .b_sel(x_b_sel),
    .b_dout(x_b_dout), .b_rvalid(x_b_rvalid)
  );

  soc_sram_dp_impl_plain #(
    .AW(6), .DW(32), .MEM_SIZE_BYTE(64), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_rl2 (
    .clk(clk), .rst(rst2), .busy(y_busy),
    .a_ce(y_a_ce), .a_we(y_a_we), .a_waddr(y_a_waddr), .a_din(y_a_din), .a_sel(y_a_sel),
    .a_dout(y_a_dout), .a_rvalid(y_a_rvalid),
    .b_ce(y_b_ce), .b_we(y_b_we), .b_waddr(y_b_waddr), .b_din(y_b_din), .b_sel(y_b_sel),
    .b_dout(y_b_dout), .b_rvalid(y_b_rvalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  // Scoreboard monitors: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (x_a_rvalid) begin
      check("a1_rvalid_expected", 32'(q_a1.size() != 0), 32'd1);
      if (q_a1.size() != 0) begin
        e = q_a1.pop_front();
        check("a1_data", x_a_dout, e.data);
        check("a1_cycle", cyc, e.cyc);
      end
    end
    if (x_b_rvalid) begin
      check("b1_rvalid_expected", 32'(q_b1.size() != 0), 32'd1);
      if (q_b1.size() != 0) begin
        e = q_b1.pop_front();
        check("b1_data", x_b_dout, e.data);
        check("b1_cycle", cyc, e.cyc);
      end
    end
    if (y_a_rvalid) begin
      check("a2_rvalid_expected", 32'(q_a2.size() != 0), 32'd1);
      if (q_a2.size() != 0) begin
        e = q_a2.pop_front();
        check("a2_data", y_a_dout, e.data);
        check("a2_cycle", cyc, e.cyc);
      end
    end
    if (y_b_rvalid) begin
      check("b2_rvalid_expected", 32'(q_b2.size() != 0), 32'd1);
      if (q_b2.size() != 0) begin
        e = q_b2.pop_front();
        check("b2_data", y_b_dout, e.data);
        check("b2_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic sa1(input bit we, input int ad, input logic [31:0] d, input logic [3:0] s);
    x_a_ce = 1'b1; x_a_we = we; x_a_waddr = ad[3:0]; x_a_din = d; x_a_sel = s;
  endtask
  task automatic sb1(input bit we, input int ad, input logic [31:0] d, input logic [3:0] s);
    x_b_ce = 1'b1; x_b_we = we; x_b_waddr = ad[3:0]; x_b_din = d; x_b_sel = s;
  endtask
  task automatic sa2(input bit we, input int ad, input logic [31:0] d, input logic [3:0] s);
    y_a_ce = 1'b1; y_a_we = we; y_a_waddr = ad[3:0]; y_a_din = d; y_a_sel = s;
  endtask
  task automatic sb2(input bit we, input int ad, input logic [31:0] d, input logic [3:0] s);
    y_b_ce = 1'b1; y_b_we = we; y_b_waddr = ad[3:0]; y_b_din = d; y_b_sel = s;
  endtask

  // Issue one cycle on u_rl1: queue read expectations, update the model, advance.
  task automatic go1();
    logic [31:0] r;
    if (x_a_ce && !x_a_we) begin
      r = m1[x_a_waddr];
`ifdef SOC_SRAM_DP_FWD_EN
      if (x_b_ce && x_b_we && x_b_waddr == x_a_waddr) r = merge(r, x_b_din, x_b_sel);
`endif
      q_a1.push_back('{r, cyc + 1});
    end
    if (x_b_ce && !x_b_we) begin
      r = m1[x_b_waddr];
`ifdef SOC_SRAM_DP_FWD_EN
      if (x_a_ce && x_a_we && x_a_waddr == x_b_waddr) r = merge(r, x_a_din, x_a_sel);
`endif
      q_b1.push_back('{r, cyc + 1});
    end
    if (x_b_ce && x_b_we) m1[x_b_waddr] = merge(m1[x_b_waddr], x_b_din, x_b_sel);
    if (x_a_ce && x_a_we) m1[x_a_waddr] = merge(m1[x_a_waddr], x_a_din, x_a_sel);
    @(negedge clk);
    x_a_ce = 1'b0; x_b_ce = 1'b0;
  endtask

  // Same for u_rl2; requests while busy or in reset are expected to be dropped.
  task automatic go2();
    logic [31:0] r;
    bit ok;
    ok = !y_busy && rst2;
    if (ok && y_a_ce && !y_a_we) begin
      r = m2[y_a_waddr];
`ifdef SOC_SRAM_DP_FWD_EN
      if (y_b_ce && y_b_we && y_b_waddr == y_a_waddr) r = merge(r, y_b_din, y_b_sel);
`endif
      q_a2.push_back('{r, cyc + 2});
    end
    if (ok && y_b_ce && !y_b_we) begin
      r = m2[y_b_waddr];
`ifdef SOC_SRAM_DP_FWD_EN
      if (y_a_ce && y_a_we && y_a_waddr == y_b_waddr) r = merge(r, y_a_din, y_a_sel);
`endif
      q_b2.push_back('{r, cyc + 2});
    end
    if (ok && y_b_ce && y_b_we) m2[y_b_waddr] = merge(m2[y_b_waddr], y_b_din, y_b_sel);
    if (ok && y_a_ce && y_a_we) m2[y_a_waddr] = merge(m2[y_a_waddr], y_a_din, y_a_sel);
    @(negedge clk);
    y_a_ce = 1'b0; y_b_ce = 1'b0;
  endtask

  // Count negedges with busy high, bounded so a stuck sequencer still ends.
  task automatic measure_busy2(output int n);
    n = 0;
    while (y_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int rd_list[4];
    rd_list = '{5, 9, 3, 10};
    rst1 = 1'b0; rst2 = 1'b0;
    x_a_ce = 0; x_a_we = 0; x_a_waddr = 0; x_a_din = 0; x_a_sel = 0;
    x_b_ce = 0; x_b_we = 0; x_b_waddr = 0; x_b_din = 0; x_b_sel = 0;
    y_a_ce = 0; y_a_we = 0; y_a_waddr = 0; y_a_din = 0; y_a_sel = 0;
    y_b_ce = 0; y_b_we = 0; y_b_waddr = 0; y_b_din = 0; y_b_sel = 0;
    repeat (3) @(negedge clk);

    check("rst_a1_dout", x_a_dout, 32'h0);
    check("rst_a1_rvalid", {31'b0, x_a_rvalid}, 32'h0);
    check("rst_b1_dout", x_b_dout, 32'h0);
    check("rst_busy1", {31'b0, x_busy}, 32'h0);
    check("rst_busy2", {31'b0, y_busy}, 32'h1);
    check("rst_a2_dout", y_a_dout, 32'h0);
    check("rst_b2_rvalid", {31'b0, y_b_rvalid}, 32'h0);

    // Release both resets. While u_rl2 clears, requests are held on it.
    rst1 = 1'b1; rst2 = 1'b1;
    y_a_ce = 1'b1; y_a_we = 1'b1; y_a_waddr = 4'd2; y_a_din = 32'hFFFF_FFFF; y_a_sel = 4'hF;
    y_b_ce = 1'b1; y_b_we = 1'b0; y_b_waddr = 4'd2;
    measure_busy2(n);
    y_a_ce = 1'b0; y_b_ce = 1'b0;
    check("clear_busy_cycles", n, 32'd16);
    for (int k = 0; k < 16; k++) m2[k] = 32'h0;
    // The first non-busy cycle is usable; all words must read zero.
    for (int k = 0; k < 16; k++) begin
      sa2(0, k, 32'h0, 4'h0); sb2(0, 15 - k, 32'h0, 4'h0); go2();
    end

    // Partial write over a full write.
    sa1(1, 5, 32'hDEAD_BEEF, 4'hF); go1();
    sa1(1, 5, 32'h0000_5500, 4'h2); go1();
    sb1(0, 5, 32'h0, 4'h0); go1();
    check("t1_b_dout", x_b_dout, 32'hDEAD_55EF);
    check("t1_b_rvalid_hi", {31'b0, x_b_rvalid}, 32'h1);
    @(negedge clk);
    check("t1_b_rvalid_pulse", {31'b0, x_b_rvalid}, 32'h0);

    // Write/write collision on word 9.
    sa1(1, 9, 32'h1111_1111, 4'h3); sb1(1, 9, 32'h2222_2222, 4'hF); go1();
    sa1(0, 9, 32'h0, 4'h0); sb1(0, 9, 32'h0, 4'h0); go1();
    check("t2_a_dout", x_a_dout, 32'h2222_1111);

    // Cross-port read/write collision: B writes, A reads word 3.
    sa1(1, 3, 32'hAAAA_AAAA, 4'hF); sb1(1, 7, 32'h0102_0304, 4'hF); go1();
    sa1(0, 3, 32'h0, 4'h0); sb1(1, 3, 32'h1234_5678, 4'hC); go1();
`ifdef SOC_SRAM_DP_FWD_EN
    check("t3_a_dout_same", x_a_dout, 32'h1234_AAAA);
`else
    check("t3_a_dout_same", x_a_dout, 32'hAAAA_AAAA);
`endif
    sa1(0, 3, 32'h0, 4'h0); go1();
    check("t3_a_dout_next", x_a_dout, 32'h1234_AAAA);

    // Mirror case: A writes, B reads word 7.
    sa1(1, 7, 32'hFFEE_DDCC, 4'h1); sb1(0, 7, 32'h0, 4'h0); go1();
`ifdef SOC_SRAM_DP_FWD_EN
    check("t4_b_dout_same", x_b_dout, 32'h0102_03CC);
`else
    check("t4_b_dout_same", x_b_dout, 32'h0102_0304);
`endif
    sb1(0, 7, 32'h0, 4'h0); go1();
    check("t4_b_dout_next", x_b_dout, 32'h0102_03CC);

    // Disjoint lanes from both ports land in the same word.
    sa1(1, 10, 32'h5555_5555, 4'hF); go1();
    sa1(1, 10, 32'h0000_00AA, 4'h1); sb1(1, 10, 32'h00BB_0000, 4'h4); go1();
    sb1(0, 10, 32'h0, 4'h0); go1();
    check("t5_b_dout", x_b_dout, 32'h55BB_55AA);

    // Back-to-back reads on both ports, then outputs hold.
    for (int k = 0; k < 4; k++) begin
      sa1(0, rd_list[k], 32'h0, 4'h0); sb1(0, rd_list[3 - k], 32'h0, 4'h0); go1();
    end
    repeat (3) @(negedge clk);
    check("hold_a1_dout", x_a_dout, 32'h55BB_55AA);
    check("hold_b1_dout", x_b_dout, 32'hDEAD_55EF);
    check("hold_a1_rvalid", {31'b0, x_a_rvalid}, 32'h0);
    rst1 = 1'b0;
    @(negedge clk);
    check("rst1_a_dout", x_a_dout, 32'h0);
    check("rst1_b_dout", x_b_dout, 32'h0);
    rst1 = 1'b1;

    // Two-cycle pipeline: fill, then four back-to-back reads on each port.
    for (int k = 0; k < 4; k++) begin
      sa2(1, k, 32'hC0DE_0000 | k, 4'hF); sb2(1, 12 + k, 32'hBEEF_0000 | k, 4'hF); go2();
    end
    for (int k = 0; k < 4; k++) begin
      sa2(0, k, 32'h0, 4'h0); sb2(0, 15 - k, 32'h0, 4'h0); go2();
    end
    check("rl2_a_third", y_a_dout, 32'hC0DE_0002);
    check("rl2_a_third_valid", {31'b0, y_a_rvalid}, 32'h1);
    @(negedge clk);
    check("rl2_a_fourth", y_a_dout, 32'hC0DE_0003);
    @(negedge clk);
    check("rl2_a_idle", {31'b0, y_a_rvalid}, 32'h0);

    // Reset with a read in flight: the read is dropped and outputs clear.
    y_a_ce = 1'b1; y_a_we = 1'b0; y_a_waddr = 4'd1;
    @(negedge clk);
    y_a_ce = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("inflight_rvalid", {31'b0, y_a_rvalid}, 32'h0);
    check("inflight_dout", y_a_dout, 32'h0);
    check("inflight_busy", {31'b0, y_busy}, 32'h1);
    @(negedge clk);
    check("inflight_rvalid2", {31'b0, y_a_rvalid}, 32'h0);
    rst2 = 1'b1;
    measure_busy2(n);
    check("reclear_busy_cycles", n, 32'd16);
    for (int k = 0; k < 16; k++) m2[k] = 32'h0;

    // Abort a clear at cycle 7; the restarted clear must cover every word.
    sa2(1, 14, 32'h1357_9BDF, 4'hF); sb2(1, 15, 32'h2468_ACE0, 4'hF); go2();
    rst2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    repeat (7) @(negedge clk);
    check("midclear_busy", {31'b0, y_busy}, 32'h1);
    rst2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b1;
    measure_busy2(n);
    check("restart_busy_cycles", n, 32'd16);
    for (int k = 0; k < 16; k++) m2[k] = 32'h0;
    sa2(0, 14, 32'h0, 4'h0); sb2(0, 15, 32'h0, 4'h0); go2();
    sa2(0, 1, 32'h0, 4'h0); sb2(0, 3, 32'h0, 4'h0); go2();

    repeat (4) @(negedge clk);
    check("sb_a1_drained", q_a1.size(), 32'd0);
    check("sb_b1_drained", q_b1.size(), 32'd0);
    check("sb_a2_drained", q_a2.size(), 32'd0);
    check("sb_b2_drained", q_b2.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
